// File: rtl/spm_mp_ram.sv
// N-port single-clock scratchpad with byte enables, 1/2-cycle read latency,
// selectable read-during-write data and a post-reset clear sequencer.
module spm_mp_ram #(
   parameter int unsigned NPORTS       = 2,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MEMSIZE_KB   = 128,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned RDW_MODE     = 0,
   parameter int unsigned CLEAR_ON_RST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        req_valid,
   output logic [NPORTS-1:0]        req_ready,
   input  logic [NPORTS-1:0]        req_we,
   input  logic [NPORTS*DATA_W/8-1:0] req_be,
   input  logic [NPORTS*ADDR_W-1:0] req_addr,
   input  logic [NPORTS*DATA_W-1:0] req_wdata,
   output logic [NPORTS-1:0]        rsp_valid,
   output logic [NPORTS*DATA_W-1:0] rsp_rdata,
   output logic                     init_done,
   output logic                     collision
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = MEMSIZE_KB * 1024 / NB;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          NP    = int'(NPORTS);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            r_state, w_state_nxt;
   logic [AW-1:0]     r_cnt, w_cnt_nxt;
   logic              r_init_done;
   logic              w_clr_we;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [NPORTS-1:0] w_acc, w_wr;
   logic [AW-1:0]     w_idx [NPORTS];
   logic [DATA_W-1:0] w_old [NPORTS];
   logic [DATA_W-1:0] w_new [NPORTS];
   logic [DATA_W-1:0] w_rsp [NPORTS];
   logic              w_coll;
   logic              r_coll;

   logic [NPORTS-1:0] r_v1;
   logic [DATA_W-1:0] r_d1 [NPORTS];

   // Upper address bits are intentionally dropped (addresses alias mod DEPTH)
   logic w_unused_addr;
   assign w_unused_addr = ^req_addr;

   assign req_ready = {NPORTS{r_init_done}};
   assign init_done = r_init_done;
   assign collision = r_coll;
   assign w_acc     = req_valid & req_ready;
   assign w_wr      = w_acc & req_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_CLEAR;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_init_done <= (w_state_nxt == S_READY);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      case (r_state)
         S_CLEAR: begin
            if (CLEAR_ON_RST != 0) begin
               w_clr_we  = 1'b1;
               w_cnt_nxt = r_cnt + AW'(1);
               if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = S_READY;
            end else begin
               w_state_nxt = S_READY;
            end
         end
         S_READY: w_state_nxt = S_READY;
      endcase
   end

   always_comb begin
      for (int p = 0; p < NP; p++) w_idx[p] = req_addr[p*ADDR_W +: AW];
   end

   // Per-port view of the word after this edge: lowest-index enabled port wins each lane
   always_comb begin
      w_coll = 1'b0;
      for (int p = 0; p < NP; p++) begin
         w_old[p] = r_mem[w_idx[p]];
         w_new[p] = w_old[p];
         for (int q = NP - 1; q >= 0; q--) begin
            if (w_wr[q] && (w_idx[q] == w_idx[p])) begin
               for (int b = 0; b < int'(NB); b++) begin
                  if (req_be[q*NB + b]) w_new[p][b*8 +: 8] = req_wdata[q*DATA_W + b*8 +: 8];
               end
            end
         end
         w_rsp[p] = ((RDW_MODE == 0) && w_wr[p]) ? w_new[p] : w_old[p];
         for (int q = p + 1; q < NP; q++) begin
            if (w_wr[p] && w_wr[q] && (w_idx[p] == w_idx[q]) &&
                ((req_be[p*NB +: NB] & req_be[q*NB +: NB]) != '0)) w_coll = 1'b1;
         end
      end
   end

   // Array write; descending port order makes the lowest port's lane the last assignment
   always_ff @(posedge clk) begin
      if (w_clr_we) r_mem[r_cnt] <= '0;
      for (int p = NP - 1; p >= 0; p--) begin
         if (w_wr[p]) begin
            for (int b = 0; b < int'(NB); b++) begin
               if (req_be[p*NB + b]) r_mem[w_idx[p]][b*8 +: 8] <= req_wdata[p*DATA_W + b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1   <= '0;
         r_coll <= 1'b0;
         for (int p = 0; p < NP; p++) r_d1[p] <= '0;
      end else begin
         r_v1   <= w_acc;
         r_coll <= w_coll;
         for (int p = 0; p < NP; p++) begin
            if (w_acc[p]) r_d1[p] <= w_rsp[p];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [NPORTS-1:0] r_v2;
         logic [DATA_W-1:0] r_d2 [NPORTS];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_v2 <= '0;
               for (int p = 0; p < NP; p++) r_d2[p] <= '0;
            end else begin
               r_v2 <= r_v1;
               for (int p = 0; p < NP; p++) begin
                  if (r_v1[p]) r_d2[p] <= r_d1[p];
               end
            end
         end

         assign rsp_valid = r_v2;
         for (genvar p = 0; p < NP; p++) begin : g_out
            assign rsp_rdata[p*DATA_W +: DATA_W] = r_d2[p];
         end
      end else begin : g_lat1
         assign rsp_valid = r_v1;
         for (genvar p = 0; p < NP; p++) begin : g_out
            assign rsp_rdata[p*DATA_W +: DATA_W] = r_d1[p];
         end
      end
   endgenerate

endmodule

// File: tb/tb_spm_mp_ram.sv
// Bench for spm_mp_ram: two instances (latency 1 / write-first, latency 2 / read-first)
// share one stimulus stream; responses are checked against a queued scoreboard.
module tb_spm_mp_ram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0, req_we = '0;
   logic [7:0]  req_be = '0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  rdy_a, rdy_b, vld_a, vld_b;
   logic [63:0] rd_a, rd_b;
   logic        init_a, init_b, coll_a, coll_b;

   typedef struct {
      logic [1:0]  v, we;
      logic [3:0]  be0, be1;
      logic [31:0] a0, d0, a1, d1;
      logic [31:0] e0m0, e0m1, e1m0, e1m1;
      logic        coll;
   } vec_t;
   typedef struct { int due; logic [31:0] data; } exp_t;
   typedef struct { int due; logic val; } cexp_t;

   exp_t  sb [4][$];
   cexp_t cq [$];
   vec_t  tbl [13];
   int    n_cmp = 0, n_err = 0, cyc = 0;
   bit    mon_en = 1'b0;

   spm_mp_ram #(.NPORTS(2), .ADDR_W(32), .DATA_W(32), .MEMSIZE_KB(1),
                .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
      .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld_a),
      .rsp_rdata(rd_a), .init_done(init_a), .collision(coll_a));

   spm_mp_ram #(.NPORTS(2), .ADDR_W(32), .DATA_W(32), .MEMSIZE_KB(1),
                .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
      .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld_b),
      .rsp_rdata(rd_b), .init_done(init_b), .collision(coll_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                               input logic [3:0] be0, input logic [3:0] be1,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic [31:0] e0m0, input logic [31:0] e0m1,
                               input logic [31:0] e1m0, input logic [31:0] e1m1,
                               input logic coll);
      vec_t t;
      t.v = v; t.we = we; t.be0 = be0; t.be1 = be1;
      t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
      t.e0m0 = e0m0; t.e0m1 = e0m1; t.e1m0 = e1m0; t.e1m1 = e1m1; t.coll = coll;
      return t;
   endfunction

   // Drive one cycle; accepted at the next posedge, so latency-L data is due at cyc+L
   task automatic drive(input vec_t t);
      @(negedge clk);
      req_valid = t.v; req_we = t.we; req_be = {t.be1, t.be0};
      req_addr = {t.a1, t.a0}; req_wdata = {t.d1, t.d0};
      if (t.v[0]) begin
         sb[0].push_back('{cyc + 1, t.e0m0});
         sb[2].push_back('{cyc + 2, t.e0m1});
      end
      if (t.v[1]) begin
         sb[1].push_back('{cyc + 1, t.e1m0});
         sb[3].push_back('{cyc + 2, t.e1m1});
      end
      cq.push_back('{cyc + 1, t.coll});
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      req_valid = '0; req_we = '0; req_be = '0;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready_a"}, 64'(rdy_a), 64'(0));
      chk({tag, "_ready_b"}, 64'(rdy_b), 64'(0));
      chk({tag, "_valid_a"}, 64'(vld_a), 64'(0));
      chk({tag, "_valid_b"}, 64'(vld_b), 64'(0));
      chk({tag, "_rdata_a"}, rd_a, 64'(0));
      chk({tag, "_rdata_b"}, rd_b, 64'(0));
      chk({tag, "_init_a"}, 64'(init_a), 64'(0));
      chk({tag, "_coll_a"}, 64'(coll_a), 64'(0));
      chk({tag, "_coll_b"}, 64'(coll_b), 64'(0));
   endtask

   // Caller releases rst at a negedge; init_done must first read 1 after exactly 256 edges
   task automatic wait_init(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!init_a && k < 1000);
      chk({tag, "_init_cycles"}, 64'(k), 64'(256));
      chk({tag, "_init_b"}, 64'(init_b), 64'(1));
      chk({tag, "_ready_a"}, 64'(rdy_a), 64'(2'b11));
   endtask

   task automatic chk_drained(input string tag);
      for (int s = 0; s < 4; s++) chk($sformatf("%s_pending_s%0d", tag, s), 64'(sb[s].size()), 64'(0));
   endtask

   always @(negedge clk) begin
      logic        v;
      logic [31:0] d;
      if (mon_en) begin
         for (int s = 0; s < 4; s++) begin
            v = (s < 2) ? vld_a[s % 2] : vld_b[s % 2];
            d = (s < 2) ? rd_a[(s % 2)*32 +: 32] : rd_b[(s % 2)*32 +: 32];
            if (v) begin
               if (sb[s].size() == 0 || sb[s][0].due != cyc) begin
                  n_cmp++; n_err++;
                  $display("FAIL rsp_unexpected s%0d: got valid 1 want 0 (cyc %0d)", s, cyc);
               end else begin
                  chk($sformatf("rsp_data_s%0d", s), 64'(d), 64'(sb[s][0].data));
                  sb[s].delete(0);
               end
            end else if (sb[s].size() > 0 && sb[s][0].due <= cyc) begin
               n_cmp++; n_err++;
               $display("FAIL rsp_missing s%0d: got valid 0 want 1 (cyc %0d)", s, cyc);
               sb[s].delete(0);
            end
         end
         if (cq.size() > 0 && cq[0].due == cyc) begin
            chk("collision_a", 64'(coll_a), 64'(cq[0].val));
            chk("collision_b", 64'(coll_b), 64'(cq[0].val));
            cq.delete(0);
         end
      end
   end

   initial begin
      //          v      we     be0   be1   a0        d0            a1        d1            e0m0          e0m1          e1m0          e1m1          coll
      tbl[0]  = mk(2'b11, 2'b01, 4'hF, 4'h0, 32'h010, 32'hDEADBEEF, 32'h010, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        1'b0);
      tbl[1]  = mk(2'b01, 2'b01, 4'h2, 4'h0, 32'h010, 32'h0000AA00, 32'h0,   32'h0,        32'hDEADAAEF, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0);
      tbl[2]  = mk(2'b11, 2'b00, 4'h0, 4'h0, 32'h0FF, 32'h0,        32'h000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
      tbl[3]  = mk(2'b11, 2'b00, 4'h0, 4'h0, 32'h010, 32'h0,        32'h110, 32'h0,        32'hDEADAAEF, 32'hDEADAAEF, 32'hDEADAAEF, 32'hDEADAAEF, 1'b0);
      tbl[4]  = mk(2'b11, 2'b11, 4'hF, 4'hF, 32'h020, 32'h11111111, 32'h020, 32'h22222222, 32'h11111111, 32'h0,        32'h11111111, 32'h0,        1'b1);
      tbl[5]  = mk(2'b01, 2'b00, 4'h0, 4'h0, 32'h020, 32'h0,        32'h0,   32'h0,        32'h11111111, 32'h11111111, 32'h0,        32'h0,        1'b0);
      tbl[6]  = mk(2'b11, 2'b11, 4'h3, 4'hC, 32'h020, 32'h33333333, 32'h020, 32'h44444444, 32'h44443333, 32'h11111111, 32'h44443333, 32'h11111111, 1'b0);
      tbl[7]  = mk(2'b11, 2'b00, 4'h0, 4'h0, 32'h020, 32'h0,        32'h020, 32'h0,        32'h44443333, 32'h44443333, 32'h44443333, 32'h44443333, 1'b0);
      tbl[8]  = mk(2'b11, 2'b01, 4'hF, 4'h0, 32'h030, 32'h00000055, 32'h030, 32'h0,        32'h00000055, 32'h0,        32'h0,        32'h0,        1'b0);
      tbl[9]  = mk(2'b11, 2'b10, 4'h0, 4'h0, 32'h030, 32'h0,        32'h030, 32'hAAAAAAAA, 32'h00000055, 32'h00000055, 32'h00000055, 32'h00000055, 1'b0);
      tbl[10] = mk(2'b11, 2'b00, 4'h0, 4'h0, 32'h030, 32'h0,        32'h130, 32'h0,        32'h00000055, 32'h00000055, 32'h00000055, 32'h00000055, 1'b0);
      tbl[11] = mk(2'b11, 2'b11, 4'h1, 4'h3, 32'h040, 32'hAABBCCDD, 32'h040, 32'h11223344, 32'h000033DD, 32'h0,        32'h000033DD, 32'h0,        1'b1);
      tbl[12] = mk(2'b01, 2'b00, 4'h0, 4'h0, 32'h040, 32'h0,        32'h0,   32'h0,        32'h000033DD, 32'h000033DD, 32'h0,        32'h0,        1'b0);

      // Power-on reset and clear timing
      repeat (3) @(negedge clk);
      chk_reset("por");
      rst = 1'b0;
      wait_init("por");
      mon_en = 1'b1;

      // Vector table, back-to-back every cycle
      for (int i = 0; i < 13; i++) drive(tbl[i]);
      idle(5);
      chk("hold_a_p0", 64'(rd_a[31:0]),  64'(32'h000033DD));
      chk("hold_b_p0", 64'(rd_b[31:0]),  64'(32'h000033DD));
      chk("hold_a_p1", 64'(rd_a[63:32]), 64'(32'h000033DD));
      chk("hold_b_p1", 64'(rd_b[63:32]), 64'(32'h0));
      chk_drained("table");

      // Reset in the middle of streaming reads
      for (int i = 0; i < 3; i++)
         drive(mk(2'b11, 2'b00, 4'h0, 4'h0, 32'h010, 32'h0, 32'h010, 32'h0,
                  32'hDEADAAEF, 32'hDEADAAEF, 32'hDEADAAEF, 32'hDEADAAEF, 1'b0));
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      req_valid = '0;
      #1;
      chk("midtraffic_valid_a", 64'(vld_a), 64'(0));
      chk("midtraffic_valid_b", 64'(vld_b), 64'(0));
      for (int s = 0; s < 4; s++) sb[s].delete();
      cq.delete();
      repeat (2) @(negedge clk);
      chk_reset("midtraffic");
      rst = 1'b0;
      wait_init("midtraffic");
      mon_en = 1'b1;

      // Plant a word beyond the partial-clear point, then reset at clear count 100
      drive(mk(2'b01, 2'b01, 4'hF, 4'h0, 32'h080, 32'h12345678, 32'h0, 32'h0,
               32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0));
      idle(4);
      chk_drained("plant");
      mon_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("midclear_not_done", 64'(init_a), 64'(0));
      rst = 1'b1;
      #1;
      chk("midclear_rst_init", 64'(init_b), 64'(0));
      repeat (2) @(negedge clk);
      chk_reset("midclear");
      rst = 1'b0;
      wait_init("midclear");
      mon_en = 1'b1;

      // Whole array cleared again, including the planted word
      drive(mk(2'b11, 2'b00, 4'h0, 4'h0, 32'h080, 32'h0, 32'h010, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
      idle(5);
      chk_drained("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
